// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered -- buffered UART transmitter.
//
// Bytes written from the CPU side are queued in a small FIFO and sent
// LSB first as 8N1 frames (start, DATA_WIDTH data bits, stop). Back-to-back
// frames follow each other with no idle gap while the FIFO has data.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is sent between the data and the stop bit (8E1)
//   undefined -> plain 8N1, no parity logic
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous active-low reset
//   tx_parallel_data_in in   byte to enqueue
//   tx_strobe_write     in   one-cycle write strobe
//   tx_status_clear     in   clears the sticky overflow flag
//   tx_serial_out       out  serial line, idle high
//   tx_busy             out  a frame is on the line
//   tx_fifo_full        out  FIFO holds FIFO_DEPTH entries
//   tx_fifo_empty       out  FIFO holds no entries
//   tx_status_reg       out  [0] sticky overflow, [1] busy or FIFO not empty
module uart_tx_buffered #(
  parameter int CLOCK_SPEED = 2_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_parallel_data_in,
  input  logic                  tx_strobe_write,
  input  logic                  tx_status_clear,
  output logic                  tx_serial_out,
  output logic                  tx_busy,
  output logic                  tx_fifo_full,
  output logic                  tx_fifo_empty,
  output logic [1:0]            tx_status_reg
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BAUD_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]     count_q, count_d;
  logic                  full_q, empty_q, ovf_q, pending_q;

  // Transmitter
  state_t                state_q;
  logic [CNT_W-1:0]      baud_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_nx;
  logic                  line_q, busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  logic                  tick, frame_end, pop, write_ok, overflow_set;
  logic [DATA_WIDTH-1:0] head;

  assign head         = mem_q[rd_ptr_q];
  assign tick         = (baud_q == LAST_TICK);
  assign frame_end    = (state_q == S_STOP) && tick;
  // Pops happen only from IDLE or on the last stop cycle, so consecutive
  // frames are seamless.
  assign pop          = (count_q != '0) && ((state_q == S_IDLE) || frame_end);
  // Fullness uses the count before this cycle's pop.
  assign write_ok     = tx_strobe_write && (count_q != DEPTH_C);
  assign overflow_set = tx_strobe_write && (count_q == DEPTH_C);
  assign busy_d       = pop || (busy_q && !frame_end);
  assign shift_nx     = shift_q >> 1;

  always_comb begin
    count_d = count_q;
    if (write_ok && !pop) begin
      count_d = count_q + FCNT_ONE;
    end else if (!write_ok && pop) begin
      count_d = count_q - FCNT_ONE;
    end
  end

  // Storage has no reset; the cleared count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem_q[wr_ptr_q] <= tx_parallel_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      if (write_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q   <= count_d;
      full_q    <= (count_d == DEPTH_C);
      empty_q   <= (count_d == '0);
      // A new overflow beats a simultaneous clear.
      if (overflow_set) begin
        ovf_q <= 1'b1;
      end else if (tx_status_clear) begin
        ovf_q <= 1'b0;
      end
      pending_q <= busy_d || (count_d != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      if (pop) begin
        shift_q  <= head;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^head;
`endif
      end
      case (state_q)
        S_IDLE: begin
          line_q <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            state_q <= S_START;
            line_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
            line_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (tick) begin
            baud_q <= '0;
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              line_q  <= parity_q;
`else
              state_q <= S_STOP;
              line_q  <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + IDX_ONE;
              shift_q   <= shift_nx;
              line_q    <= shift_nx[0];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            line_q  <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= S_START;
              line_q  <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              line_q  <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          line_q  <= 1'b1;
          baud_q  <= '0;
        end
      endcase
    end
  end

  assign tx_serial_out = line_q;
  assign tx_busy       = busy_q;
  assign tx_fifo_full  = full_q;
  assign tx_fifo_empty = empty_q;
  assign tx_status_reg = {pending_q, ovf_q};

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered. A queue-and-timestamp reference model
// predicts every output after every clock edge; table vectors probe the
// line mid-bit; hand sequences cover burst, overflow and reset corners.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int CLOCK_SPEED = 2_000_000;
  localparam int BAUD_RATE   = 9600;
  localparam int DATA_WIDTH  = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int CPB         = CLOCK_SPEED / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS  = 11;
`else
  localparam int FRAME_BITS  = 10;
`endif
  localparam int FRAME_CYC   = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr = 1'b0;
  logic       clr = 1'b0;
  logic       tx_serial_out, tx_busy, tx_fifo_full, tx_fifo_empty;
  logic [1:0] tx_status_reg;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLOCK_SPEED(CLOCK_SPEED),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .tx_parallel_data_in(din),
    .tx_strobe_write    (wr),
    .tx_status_clear    (clr),
    .tx_serial_out      (tx_serial_out),
    .tx_busy            (tx_busy),
    .tx_fifo_full       (tx_fifo_full),
    .tx_fifo_empty      (tx_fifo_empty),
    .tx_status_reg      (tx_status_reg)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending bytes, the frame on the line and when it ends.
  logic [7:0] m_q[$];
  longint     edge_no = 0;
  longint     m_tx_end = 0;
  longint     m_frame_start = 0;
  logic [7:0] m_frame_byte = 8'h00;
  bit         m_frame_valid = 0;
  bit         m_ovf = 0;
  bit         last_accepted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && FRAME_BITS == 11) return ^d;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_tx_end = 0;
    m_frame_valid = 0;
    m_ovf = 0;
  endtask

  task automatic check_outputs();
    logic el;
    logic busy_e;
    busy_e = m_frame_valid && (edge_no < m_tx_end);
    el = 1'b1;
    if (busy_e) el = frame_bit(m_frame_byte, int'((edge_no - m_frame_start) / CPB));
    chk("line", 64'(tx_serial_out), 64'(el));
    chk("busy", 64'(tx_busy), 64'(busy_e));
    chk("empty", 64'(tx_fifo_empty), 64'(m_q.size() == 0));
    chk("full", 64'(tx_fifo_full), 64'(m_q.size() == FIFO_DEPTH));
    chk("status", 64'(tx_status_reg), 64'({busy_e || (m_q.size() != 0), m_ovf}));
  endtask

  // One clock edge: update the model from the inputs in force, then check.
  task automatic step();
    logic w, c;
    logic [7:0] d;
    bit full_pre, pop_now;
    w = wr; c = clr; d = din;
    @(posedge clk);
    edge_no++;
    if (!reset) begin
      model_reset();
    end else begin
      full_pre = (m_q.size() == FIFO_DEPTH);
      pop_now  = (m_q.size() != 0) && (edge_no >= m_tx_end);
      if (pop_now) begin
        m_frame_byte  = m_q.pop_front();
        m_frame_start = edge_no;
        m_tx_end      = edge_no + FRAME_CYC;
        m_frame_valid = 1;
      end
      last_accepted = 0;
      if (w && full_pre) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (w && !full_pre) begin
        m_q.push_back(d);
        last_accepted = 1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic with_clear);
    din = d; wr = 1'b1; clr = with_clear;
    step();
    wr = 1'b0; clr = 1'b0;
    $display("write 0x%02h clear=%0d at edge %0d: %s", d, with_clear, edge_no,
             last_accepted ? "accepted" : "dropped (fifo full)");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tx_busy || !tx_fifo_empty) && n < 12 * FRAME_CYC) begin
      step();
      n++;
    end
    chk("drain_bounded", 64'(n < 12 * FRAME_CYC), 64'(1));
  endtask

  typedef struct {
    logic [7:0] data;
    logic [0:9] bits;   // start, d0..d7, stop as seen on the line
  } line_vec_t;

  line_vec_t vecs[3];

  initial begin
    int n, t;
    longint start_edge;
    logic [7:0] d;
    logic e;
    bit saw_low;

    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h41, 10'b0100000101};
    vecs[2] = '{8'hFF, 10'b0111111111};

    model_reset();
    #3 reset = 1'b0;
    repeat (3) step();
    chk("reset_line", 64'(tx_serial_out), 64'(1));
    chk("reset_busy", 64'(tx_busy), 64'(0));
    chk("reset_full", 64'(tx_fifo_full), 64'(0));
    chk("reset_empty", 64'(tx_fifo_empty), 64'(1));
    chk("reset_status", 64'(tx_status_reg), 64'(0));
    reset = 1'b1;
    repeat (3) step();

    // Mid-bit line probes from the table.
    for (int i = 0; i < 3; i++) begin
      d = vecs[i].data;
      wr_byte(d, 1'b0);
      step();   // pop edge: start bit begins
      for (int k = 0; k < FRAME_CYC; k++) begin
        if (k % CPB == CPB / 2) begin
          int b;
          b = k / CPB;
          if (b <= 8) e = vecs[i].bits[b];
          else if (b == FRAME_BITS - 1) e = vecs[i].bits[9];
          else e = ^d;
          chk($sformatf("probe_%02h_bit%0d", d, b), 64'(tx_serial_out), 64'(e));
        end
        step();
      end
      drain();
    end

    // Start latency and frame length (parity bit too when enabled).
    wr_byte(8'h07, 1'b0);
    t = 0;
    while (!tx_busy && t < 10) begin step(); t++; end
    chk("start_latency", 64'(t), 64'(1));
    chk("start_bit_low", 64'(tx_serial_out), 64'(0));
    n = 0;
    while (tx_busy && n < 2 * FRAME_CYC) begin
`ifdef UART_TX_PARITY_EN
      if (n == 9 * CPB + CPB / 2) chk("parity_bit_07", 64'(tx_serial_out), 64'(1));
`endif
      n++;
      step();
    end
    chk("frame_len", 64'(n), 64'(FRAME_CYC));
    drain();

    // Burst of four: never full, no gaps, one long busy period.
    wr_byte(8'h01, 1'b0);
    start_edge = edge_no + 1;
    chk("burst_full", 64'(tx_fifo_full), 64'(0));
    for (int i = 2; i <= 4; i++) begin
      wr_byte(8'(i), 1'b0);
      chk("burst_full", 64'(tx_fifo_full), 64'(0));
    end
    n = 0;
    while (tx_busy && n < 6 * FRAME_CYC) begin step(); n++; end
    chk("burst_busy_len", 64'(edge_no - start_edge), 64'(4 * FRAME_CYC));
    drain();

    // Overflow: fill behind an active frame, then over-write.
    wr_byte(8'h10, 1'b0);
    wr_byte(8'h20, 1'b0);
    wr_byte(8'h30, 1'b0);
    wr_byte(8'h40, 1'b0);
    wr_byte(8'h50, 1'b0);
    chk("ovf_full", 64'(tx_fifo_full), 64'(1));
    wr_byte(8'hFF, 1'b0);
    chk("ovf_set", 64'(tx_status_reg[0]), 64'(1));
    wr_byte(8'hEE, 1'b1);   // set and clear together: set wins
    chk("ovf_set_wins", 64'(tx_status_reg[0]), 64'(1));
    clr = 1'b1; step(); clr = 1'b0;
    chk("ovf_cleared", 64'(tx_status_reg[0]), 64'(0));
    n = 0;
    while (edge_no + 1 < m_tx_end && n < 2 * FRAME_CYC) begin step(); n++; end
    wr_byte(8'hDD, 1'b0);   // coincides with a pop while full
    chk("ovf_on_pop", 64'(tx_status_reg[0]), 64'(1));
    chk("ovf_pop_not_full", 64'(tx_fifo_full), 64'(0));
    clr = 1'b1; step(); clr = 1'b0;
    drain();

    // Reset in the middle of data bit 3 with another byte queued.
    wr_byte(8'h52, 1'b0);
    wr_byte(8'h3C, 1'b0);
    repeat (4 * CPB + CPB / 2) step();
    chk("pre_reset_line", 64'(tx_serial_out), 64'(0));
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset_line", 64'(tx_serial_out), 64'(1));
    chk("async_reset_empty", 64'(tx_fifo_empty), 64'(1));
    check_outputs();
    repeat (2) step();
    reset = 1'b1;
    $display("reset pulse released at edge %0d", edge_no);
    saw_low = 0;
    for (int k = 0; k < FRAME_CYC + 10; k++) begin
      step();
      if (!tx_serial_out) saw_low = 1;
    end
    chk("no_frame_after_reset", 64'(saw_low), 64'(0));

    // Randomised gaps, bursts and clears against the model.
    for (int it = 0; it < 6; it++) begin
      int gap, nb;
      gap = int'($urandom_range(0, FRAME_CYC));
      nb  = int'($urandom_range(1, 3));
      for (int g = 0; g < gap; g++) begin
        clr = ($urandom_range(0, 299) == 0);
        step();
      end
      clr = 1'b0;
      for (int j = 0; j < nb; j++)
        wr_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
